// File: rtl/gpu_cmd_pkg.sv
// rtl/gpu_cmd_pkg.sv - shared encodings and defaults for the VRAM command scheduler
//
// Purpose: command opcodes, scheduler state encoding and framebuffer geometry
//          defaults shared by vram_cmd_sched and its bench.
// Ports:   none (package).

package gpu_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_CLEAR = 2'd1,
    CMD_PIXEL = 2'd2,
    CMD_SWAP  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR_START = 3'd1,
    ST_CLR_ARM   = 3'd2,
    ST_CLR_WAIT  = 3'd3,
    ST_PIX       = 3'd4,
    ST_SWAP_WAIT = 3'd5
  } sched_state_e;

  localparam int          FB_BYTES_DEF  = 49152;
  localparam logic [17:0] BASE_ADDR_DEF = 18'd49152;

  // Cycles the scheduler waits in CLR_ARM for the clear engine to raise BUSY.
  localparam int          ARM_TIMEOUT   = 2;

endpackage

// File: rtl/vram_b_mux.sv
// rtl/vram_b_mux.sv - combinational VRAM port-B source select
//
// Purpose: the clear engine owns port B whenever it is writing; otherwise the
//          registered pixel path drives it.
// Ports:
//   clr_we/clr_addr/clr_data   in   clear engine write request
//   pix_we/pix_addr/pix_data   in   registered pixel write
//   vram_we_b/addr_b/data_b    out  muxed port-B write

module vram_b_mux (
  input  logic        clr_we,
  input  logic [17:0] clr_addr,
  input  logic [7:0]  clr_data,
  input  logic        pix_we,
  input  logic [17:0] pix_addr,
  input  logic [7:0]  pix_data,
  output logic [17:0] vram_addr_b,
  output logic [7:0]  vram_data_b,
  output logic        vram_we_b
);

  always_comb begin
    vram_addr_b = pix_addr;
    vram_data_b = pix_data;
    vram_we_b   = pix_we;
    if (clr_we) begin
      vram_addr_b = clr_addr;
      vram_data_b = clr_data;
      vram_we_b   = 1'b1;
    end
  end

endmodule

// File: rtl/vram_cmd_sched.sv
// rtl/vram_cmd_sched.sv - VRAM port-B command sequencer (CLEAR / PIXEL / SWAP)
//
// Purpose: accepts commands over valid/ready, launches and tracks the bulk
//          clear engine, writes single pixels into the back buffer, owns the
//          front/back side bit and muxes both writers onto VRAM port B.
// Build option: SCHED_VSYNC_SWAP_EN - SWAP waits for vblank_pulse before
//          toggling side; without it SWAP toggles immediately.
// Ports:
//   CLK, rst_n                      clock, async active-low reset
//   cmd_valid/ready/op/addr/color   command handshake and payload
//   vblank_pulse                    start-of-vblank strobe
//   clr_req_pulse, clr_color        start strobe and fill colour to clear engine
//   clr_busy/addr/data/we           clear engine status and write request
//   vram_addr_b/data_b/we_b         muxed VRAM port B
//   side                            front-buffer select
//   sched_busy, addr_err            not-idle flag, out-of-range PIXEL pulse

module vram_cmd_sched
  import gpu_cmd_pkg::*;
#(
  parameter int          FB_BYTES  = FB_BYTES_DEF,
  parameter logic [17:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [17:0] cmd_addr,
  input  logic [7:0]  cmd_color,
  input  logic        vblank_pulse,
  output logic        clr_req_pulse,
  output logic [7:0]  clr_color,
  input  logic        clr_busy,
  input  logic [17:0] clr_addr,
  input  logic [7:0]  clr_data,
  input  logic        clr_we,
  output logic [17:0] vram_addr_b,
  output logic [7:0]  vram_data_b,
  output logic        vram_we_b,
  output logic        side,
  output logic        sched_busy,
  output logic        addr_err
);

  localparam logic [17:0] FB_LIMIT = 18'(FB_BYTES);

  sched_state_e state_q, state_d;

  logic [17:0] lat_addr;
  logic [7:0]  lat_color;
  logic [1:0]  arm_cnt;
  logic [17:0] pix_addr;
  logic [7:0]  pix_data;
  logic        pix_we;
  logic [17:0] back_base;
  logic        pix_in_range;
  logic        arm_expired;
  logic        side_flip;
  logic        cmd_fire;

  assign cmd_ready    = (state_q == ST_IDLE);
  assign sched_busy   = (state_q != ST_IDLE);
  assign cmd_fire     = cmd_valid & cmd_ready;
  // The back buffer is whichever one is not being displayed.
  assign back_base    = side ? 18'd0 : BASE_ADDR;
  // Range check on the raw offset, before the base is added.
  assign pix_in_range = (lat_addr < FB_LIMIT);
  assign arm_expired  = (arm_cnt == 2'(ARM_TIMEOUT - 1));

`ifndef SCHED_VSYNC_SWAP_EN
  logic vblank_unused;
  assign vblank_unused = vblank_pulse;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_req_pulse = 1'b0;
    addr_err      = 1'b0;
    side_flip     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            CMD_CLEAR: state_d = ST_CLR_START;
            CMD_PIXEL: state_d = ST_PIX;
            CMD_SWAP:  state_d = ST_SWAP_WAIT;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_CLR_START: begin
        clr_req_pulse = 1'b1;
        state_d       = ST_CLR_ARM;
      end
      ST_CLR_ARM: begin
        // Give up if the engine never raises BUSY, so a dead engine
        // cannot wedge the command stream.
        if (clr_busy) begin
          state_d = ST_CLR_WAIT;
        end else if (arm_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR_WAIT: begin
        if (!clr_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_PIX: begin
        addr_err = ~pix_in_range;
        state_d  = ST_IDLE;
      end
      ST_SWAP_WAIT: begin
`ifdef SCHED_VSYNC_SWAP_EN
        if (vblank_pulse) begin
          side_flip = 1'b1;
          state_d   = ST_IDLE;
        end
`else
        side_flip = 1'b1;
        state_d   = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      clr_color <= 8'd0;
      lat_addr  <= 18'd0;
      lat_color <= 8'd0;
      arm_cnt   <= 2'd0;
      pix_addr  <= 18'd0;
      pix_data  <= 8'd0;
      pix_we    <= 1'b0;
      side      <= 1'b0;
    end else begin
      pix_we <= 1'b0;
      if (cmd_fire && cmd_op == CMD_CLEAR) begin
        clr_color <= cmd_color;
      end
      if (cmd_fire && cmd_op == CMD_PIXEL) begin
        lat_addr  <= cmd_addr;
        lat_color <= cmd_color;
      end
      if (state_q == ST_CLR_ARM) begin
        arm_cnt <= arm_cnt + 2'd1;
      end else begin
        arm_cnt <= 2'd0;
      end
      if (state_q == ST_PIX && pix_in_range) begin
        pix_addr <= back_base + lat_addr;
        pix_data <= lat_color;
        pix_we   <= 1'b1;
      end
      if (side_flip) begin
        side <= ~side;
      end
    end
  end

  vram_b_mux u_mux (
    .clr_we      (clr_we),
    .clr_addr    (clr_addr),
    .clr_data    (clr_data),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .vram_addr_b (vram_addr_b),
    .vram_data_b (vram_data_b),
    .vram_we_b   (vram_we_b)
  );

endmodule

// File: tb/tb_vram_cmd_sched.sv
// tb/tb_vram_cmd_sched.sv - self-checking bench for vram_cmd_sched

module tb_vram_cmd_sched;
  import gpu_cmd_pkg::*;

  localparam int          FB   = 16;
  localparam logic [17:0] BASE = 18'd49152;
`ifdef SCHED_VSYNC_SWAP_EN
  localparam int SWAP_LOW = 10;
`else
  localparam int SWAP_LOW = 1;
`endif

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [17:0] cmd_addr;
  logic [7:0]  cmd_color;
  logic        vblank_pulse;
  logic        clr_req_pulse;
  logic [7:0]  clr_color;
  logic        clr_busy;
  logic [17:0] clr_addr;
  logic [7:0]  clr_data;
  logic        clr_we;
  logic [17:0] vram_addr_b;
  logic [7:0]  vram_data_b;
  logic        vram_we_b;
  logic        side;
  logic        sched_busy;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;

  // Model state: expected port-B writes in order, expected side, counters.
  logic [25:0] exp_q[$];
  logic [25:0] exp_wr;
  logic        exp_side      = 1'b0;
  logic [7:0]  exp_clr_color = 8'd0;
  int          exp_pulses    = 0;
  int          exp_errs      = 0;
  int          pulse_cnt     = 0;
  int          err_cnt       = 0;
  int          wr_count      = 0;
  logic [17:0] last_wr_addr  = 18'd0;
  logic [7:0]  last_wr_data  = 8'd0;
  logic        engine_dead   = 1'b0;

  vram_cmd_sched #(.FB_BYTES(FB), .BASE_ADDR(BASE)) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_color     (cmd_color),
    .vblank_pulse  (vblank_pulse),
    .clr_req_pulse (clr_req_pulse),
    .clr_color     (clr_color),
    .clr_busy      (clr_busy),
    .clr_addr      (clr_addr),
    .clr_data      (clr_data),
    .clr_we        (clr_we),
    .vram_addr_b   (vram_addr_b),
    .vram_data_b   (vram_data_b),
    .vram_we_b     (vram_we_b),
    .side          (side),
    .sched_busy    (sched_busy),
    .addr_err      (addr_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Clear engine stand-in: one cycle after the start strobe it raises BUSY and
  // writes FB bytes of the back buffer; BUSY falls together with the last write.
  initial begin : clear_engine
    logic [17:0] base;
    logic [7:0]  col;
    logic        aborted;
    clr_busy = 1'b0; clr_we = 1'b0; clr_addr = 18'd0; clr_data = 8'd0;
    forever begin
      @(negedge CLK);
      if (rst_n && clr_req_pulse && !engine_dead) begin
        base    = side ? 18'd0 : BASE;
        col     = clr_color;
        aborted = 1'b0;
        for (int k = 0; k < FB; k++) begin
          @(negedge CLK or negedge rst_n);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          clr_busy = (k < FB - 1);
          clr_we   = 1'b1;
          clr_addr = base + 18'(k);
          clr_data = col;
        end
        if (!aborted) @(negedge CLK);
        clr_busy = 1'b0; clr_we = 1'b0; clr_addr = 18'd0; clr_data = 8'd0;
      end
    end
  end

  // Compare process: every port-B write must be the next expected one.
  always @(posedge CLK) begin
    #1;
    if (rst_n) begin
      if (vram_we_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL port_b_write actual=%0d/%0h required=no_write", vram_addr_b, vram_data_b);
        end else begin
          exp_wr = exp_q.pop_front();
          if ({vram_addr_b, vram_data_b} !== exp_wr) begin
            failures++;
            $display("FAIL port_b_write actual=%0d/%0h required=%0d/%0h",
                     vram_addr_b, vram_data_b, exp_wr[25:8], exp_wr[7:0]);
          end
        end
        wr_count++;
        last_wr_addr = vram_addr_b;
        last_wr_data = vram_data_b;
      end
      if (clr_req_pulse) begin
        pulse_cnt++;
        check("clr_color_at_pulse", clr_color, exp_clr_color);
      end
      if (addr_err) err_cnt++;
    end
  end

  task automatic model_cmd(input logic [1:0] op, input logic [17:0] a, input logic [7:0] c);
    logic [17:0] base;
    base = exp_side ? 18'd0 : BASE;
    case (op)
      CMD_CLEAR: begin
        exp_pulses++;
        exp_clr_color = c;
        if (!engine_dead)
          for (int i = 0; i < FB; i++) exp_q.push_back({base + 18'(i), c});
      end
      CMD_PIXEL: begin
        if (a < 18'(FB)) exp_q.push_back({base + a, c});
        else exp_errs++;
      end
      CMD_SWAP: exp_side = ~exp_side;
      default: ;
    endcase
  endtask

  // Holds the command valid until accepted; returns cycles spent waiting.
  task automatic send(input logic [1:0] op, input logic [17:0] a, input logic [7:0] c,
                      output int waited);
    waited = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_color = c;
    while (!cmd_ready && waited < 300) begin
      @(negedge CLK);
      waited++;
    end
    if (!cmd_ready) begin
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<300", waited);
    end
    model_cmd(op, a, c);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'd0;
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    while (low < 300) begin
      @(negedge CLK);
      if (cmd_ready) break;
      low++;
`ifdef SCHED_VSYNC_SWAP_EN
      vblank_pulse = (low == 10) && (dut.state_q == ST_SWAP_WAIT);
`endif
    end
    vblank_pulse = 1'b0;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL ready_timeout actual=%0d required=<300", low);
    end
  endtask

  initial begin : stim
    int w, low, p0, e0, n0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 18'd0;
    cmd_color = 8'd0; vblank_pulse = 1'b0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_side", side, 0);
    check("rst_clr_req", clr_req_pulse, 0);
    check("rst_clr_color", clr_color, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_vram_we", vram_we_b, 0);
    check("rst_vram_addr", vram_addr_b, 0);
    @(negedge CLK); #2 rst_n = 1'b1;

    // CLEAR A5 on side 0: 16 writes at 49152..49167.
    p0 = pulse_cnt; n0 = wr_count;
    send(CMD_CLEAR, 18'd0, 8'hA5, w);
    check("clear_busy_while_run", sched_busy, 1);
    wait_ready(low);
    check("clear_ready_low", low, FB + 1);
    check("clear_pulses", pulse_cnt - p0, 1);
    check("clear_color_out", clr_color, 8'hA5);
    check("clear_writes", wr_count - n0, 16);
    check("clear_last_addr", last_wr_addr, 18'd49167);

    // PIXEL on side 0 lands in buffer 1.
    send(CMD_PIXEL, 18'd5, 8'h3C, w);
    wait_ready(low);
    check("pixel_ready_low", low, 1);
    check("pixel_addr_side0", last_wr_addr, 18'd49157);
    check("pixel_data_side0", last_wr_data, 8'h3C);

    // SWAP, then the same PIXEL lands in buffer 0.
    send(CMD_SWAP, 18'd0, 8'd0, w);
    wait_ready(low);
    check("swap_ready_low", low, SWAP_LOW);
    check("swap_side", side, exp_side);
    check("swap_side_lit", side, 1);
    send(CMD_PIXEL, 18'd5, 8'h3C, w);
    wait_ready(low);
    check("pixel_addr_side1", last_wr_addr, 18'd5);

    // Range boundary: last valid offset, first invalid, and 49152.
    send(CMD_PIXEL, 18'd15, 8'h77, w);
    wait_ready(low);
    check("pixel_addr_max", last_wr_addr, 18'd15);
    n0 = wr_count; e0 = err_cnt;
    send(CMD_PIXEL, 18'd16, 8'h11, w);
    wait_ready(low);
    check("pixel_oob_err", err_cnt - e0, 1);
    send(CMD_PIXEL, 18'd49152, 8'h22, w);
    wait_ready(low);
    check("pixel_oob_err2", err_cnt - e0, 2);
    check("pixel_oob_nowrite", wr_count - n0, 0);

    // NOP is consumed with no effect.
    send(CMD_NOP, 18'd3, 8'h99, w);
    wait_ready(low);
    check("nop_ready_low", low, 0);
    check("nop_nowrite", wr_count - n0, 0);

    // Back to side 0; CLEAR immediately followed by a PIXEL held valid.
    send(CMD_SWAP, 18'd0, 8'd0, w);
    wait_ready(low);
    check("swap_back_side", side, 0);
    n0 = wr_count;
    send(CMD_CLEAR, 18'd0, 8'h5A, w);
    send(CMD_PIXEL, 18'd7, 8'hC3, w);
    check("pixel_behind_clear_wait", w, FB + 1);
    wait_ready(low);
    check("clear_pixel_writes", wr_count - n0, 17);
    check("clear_pixel_last", last_wr_addr, 18'd49159);

    // Engine never raises BUSY: arm timeout returns to IDLE.
    engine_dead = 1'b1;
    n0 = wr_count;
    send(CMD_CLEAR, 18'd0, 8'h0F, w);
    wait_ready(low);
    check("arm_timeout_low", low, 3);
    check("arm_timeout_nowrite", wr_count - n0, 0);
    engine_dead = 1'b0;

    // Reset in the middle of CLR_WAIT with side=1.
    send(CMD_SWAP, 18'd0, 8'd0, w);
    wait_ready(low);
    send(CMD_CLEAR, 18'd0, 8'hEE, w);
    repeat (6) @(negedge CLK);
    check("midclear_busy", sched_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", cmd_ready, 1);
    check("async_rst_busy", sched_busy, 0);
    check("async_rst_side", side, 0);
    check("async_rst_color", clr_color, 0);
    check("async_rst_we", vram_we_b, 0);
    exp_q.delete();
    exp_side = 1'b0;
    @(negedge CLK); #2 rst_n = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", cmd_ready, 1);
    send(CMD_PIXEL, 18'd2, 8'h44, w);
    wait_ready(low);
    check("post_rst_pixel", last_wr_addr, 18'd49154);

    repeat (3) @(negedge CLK);
    check("exp_queue_empty", exp_q.size(), 0);
    check("total_pulses", pulse_cnt, exp_pulses);
    check("total_addr_err", err_cnt, exp_errs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_cmd_sched.md
Name: vram_cmd_sched

Overview:
- Command sequencer for the VRAM port-B write path.
- Accepts CLEAR, PIXEL and SWAP commands over a valid/ready interface.
- Launches and tracks the bulk clear engine, issues single-pixel writes into the back buffer, and owns the front/back `side` bit.
- Muxes clear-engine and pixel writes onto the single VRAM port B. It sits between the command decoder and the clear engine / VRAM.

Parameters:
- FB_BYTES, 49152, bytes per framebuffer.
- BASE_ADDR, 18'd49152, VRAM base of buffer 1; buffer 0 is at 0.

Ports:
- CLK  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid & ready
- cmd_op  in  2  0=NOP, 1=CLEAR, 2=PIXEL, 3=SWAP
- cmd_addr  in  18  pixel offset within framebuffer (PIXEL only)
- cmd_color  in  8  fill/pixel colour
- vblank_pulse  in  1  one-cycle start-of-vblank strobe
- clr_req_pulse  out  1  start strobe to clear engine
- clr_color  out  8  colour to clear engine
- clr_busy  in  1  clear engine BUSY
- clr_addr  in  18  clear engine VRAM address
- clr_data  in  8  clear engine VRAM data
- clr_we  in  1  clear engine write enable
- vram_addr_b  out  18  muxed VRAM address
- vram_data_b  out  8  muxed VRAM data
- vram_we_b  out  1  muxed VRAM write enable
- side  out  1  front-buffer select; back base = side ? 0 : BASE_ADDR
- sched_busy  out  1  state != IDLE
- addr_err  out  1  one-cycle pulse on out-of-range PIXEL

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - cmd_ready=1, clr_req_pulse=0, clr_color=0, side=0, sched_busy=0, addr_err=0.
  - Pixel registers (addr/data/we) all 0.
  - Reset mid-clear abandons tracking; the clear engine is reset by the same system reset.
- States: IDLE, CLR_START, CLR_ARM, CLR_WAIT, PIX, SWAP_WAIT.
- cmd_ready = (state == IDLE). A command is accepted on the rising edge where cmd_valid & cmd_ready.
- IDLE:
  - NOP: consumed, no action.
  - CLEAR: latch color -> CLR_START.
  - PIXEL: latch addr/color -> PIX.
  - SWAP -> SWAP_WAIT.
- CLR_START:
  - clr_req_pulse=1 for exactly one cycle, clr_color = latched colour -> CLR_ARM.
- CLR_ARM:
  - Wait for clr_busy=1, then -> CLR_WAIT.
  - Timeout: if clr_busy is still 0 after 2 cycles -> IDLE (engine did not start).
- CLR_WAIT:
  - Wait for clr_busy=0 -> IDLE.
  - The engine's final write coincides with BUSY falling and is still passed through the mux.
- PIX, one cycle:
  - If cmd_addr < FB_BYTES: register vram_addr_b = back base + cmd_addr, vram_data_b = colour, we=1.
  - Otherwise: no write, addr_err=1.
  - -> IDLE.
  - The pixel write is visible on the cycle after PIX.
- SWAP_WAIT: toggle `side` per the Optional Feature -> IDLE.
- Port-B mux:
  - Combinational: clr_we=1 selects clr_addr/clr_data/we=1; otherwise the registered pixel path.
  - Pixel writes cannot collide with clear writes: a PIXEL is only accepted after CLR_WAIT exits, so its write lands at least 2 cycles after the last clear write.
- Address arithmetic: 18-bit unsigned, no wrap. The range check happens before the add.
- A SWAP issued during a clear cannot occur: commands serialize. The `side` value latched by the clear engine at its start pulse stays valid because `side` only changes in SWAP_WAIT.
- Throughput:
  - PIXEL: one accepted per 2 cycles.
  - CLEAR: FB_BYTES + ~3 cycles.

Optional Feature:
- SCHED_VSYNC_SWAP_EN defined: SWAP_WAIT holds until vblank_pulse=1, toggles `side` on that edge, then -> IDLE. A vblank_pulse on the entry cycle counts.
- Undefined: SWAP_WAIT toggles `side` unconditionally on its first cycle; vblank_pulse is ignored.

Decomposition:
- Shared package `gpu_cmd_pkg`:
  - cmd_op encodings (CMD_NOP/CLEAR/PIXEL/SWAP).
  - State encodings.
  - FB_BYTES/BASE_ADDR defaults.
- One natural sub-module `vram_b_mux`: the combinational port-B select. The FSM stays in the top.

Test Plan:
- CLEAR color=8'hA5 with side=0 -> one clr_req_pulse, clr_color=A5, cmd_ready low until clr_busy falls.
  - Reduced-FB_BYTES runs (e.g. 16): 16 writes at 49152..49167.
  - Default parameters: 49152 writes at 49152..98303.
- PIXEL addr=5 color=3C, side=0 -> one write addr=49157 data=3C; then SWAP, PIXEL addr=5 -> addr=5.
- PIXEL addr=49152 -> no vram_we_b, addr_err pulses one cycle, returns to IDLE.
- CLEAR immediately followed by PIXEL held valid -> PIXEL accepted only after clear completes; no cycle where both sources drive port B.
- SWAP with SCHED_VSYNC_SWAP_EN: vblank_pulse 10 cycles later -> side toggles on that edge, cmd_ready low for the 10 cycles. Without the macro -> toggles in 1 cycle.
- Assert rst_n low mid-CLR_WAIT -> all outputs reset asynchronously, state IDLE, cmd_ready=1 after release.
